// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting four requesters access to one shared UART transmitter.
// Each grant sequences a start-request phase and a frame-plus-guard wait phase.
module uart_tx_arbiter #(
    parameter int unsigned BAUD_DIV   = 10416,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned GUARD_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  gnt,
    output logic        tx_transmit,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic [1:0]  last_grant
);

    localparam int unsigned START_LEN = BAUD_DIV + 1;
    localparam int unsigned WAIT_LEN  = (FRAME_BITS + GUARD_BITS + 1) * BAUD_DIV;
    localparam int unsigned MAX_LEN   = (START_LEN > WAIT_LEN) ? START_LEN : WAIT_LEN;
    localparam int unsigned TW        = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
    localparam logic [TW-1:0] START_LOAD = TW'(START_LEN - 1);
    localparam logic [TW-1:0] WAIT_LOAD  = TW'(WAIT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          tx_transmit_q, tx_transmit_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          busy_q, busy_d;
    logic [1:0]    last_grant_q, last_grant_d;
    logic          armed_q;

    logic          win_valid;
    logic [1:0]    win_idx;
    logic [1:0]    cand_idx;

    // Search starts one past the previous winner and wraps through all four.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand_idx = 2'(32'(last_grant_q) + k);
            if (!win_valid && req[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        gnt_d        = '0;
        tx_data_d    = tx_data_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                // armed_q holds off the very first edge after reset release.
                if (armed_q && win_valid) begin
                    state_d      = START;
                    timer_d      = START_LOAD;
                    gnt_d        = 4'b0001 << win_idx;
                    tx_data_d    = req_data[{win_idx, 3'b000} +: 8];
                    last_grant_d = win_idx;
                end
            end
            START: begin
                if (timer_q == '0) begin
                    state_d = WAIT;
                    timer_d = WAIT_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            WAIT: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        tx_transmit_d = (state_d == START);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            gnt_q         <= '0;
            tx_transmit_q <= 1'b0;
            tx_data_q     <= 8'h00;
            busy_q        <= 1'b0;
            last_grant_q  <= 2'd3;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            gnt_q         <= gnt_d;
            tx_transmit_q <= tx_transmit_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= busy_d;
            last_grant_q  <= last_grant_d;
            armed_q       <= 1'b1;
        end
    end

    assign gnt         = gnt_q;
    assign tx_transmit = tx_transmit_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign last_grant  = last_grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BAUD_DIV, default 10416, SHALL be the transmitter clock cycles per bit (100 MHz / 9600).
REQ-002 Parameter FRAME_BITS, default 10, SHALL be the bits per frame (start + 8 data + stop).
REQ-003 Parameter GUARD_BITS, default 1, SHALL be the idle bit-times inserted after each frame.
REQ-004 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 reset  input  1  SHALL be asynchronous, active-low (reset=0 resets).
REQ-006 req  input  4  SHALL carry one request per requester, level, held until granted.
REQ-007 req_data  input  32  SHALL carry requester i's byte on bits [8i+7:8i].
REQ-008 gnt  output  4  SHALL be a one-hot, single-cycle grant; the byte is captured in that cycle.
REQ-009 tx_transmit  output  1  SHALL be the start request to the shared UART transmitter.
REQ-010 tx_data  output  8  SHALL be the byte presented to the transmitter, stable for the whole frame.
REQ-011 busy  output  1  SHALL be high while a frame is being sequenced.
REQ-012 last_grant  output  2  SHALL hold the index of the most recent grant.

Function
REQ-013 The FSM SHALL have three states: IDLE, START and WAIT.
REQ-014 In IDLE with any req bit high at a rising edge, the next edge SHALL enter START and assert gnt (one-hot), tx_transmit=1 and busy=1, load tx_data from the winner's slice and update last_grant.
REQ-015 Arbitration SHALL be round-robin: search order starts at (last_grant+1) mod 4 and wraps.
REQ-016 After reset, the search order SHALL start at requester 0.
REQ-017 gnt SHALL be high for exactly one cycle per grant and SHALL be zero in every other cycle.
REQ-018 START SHALL last exactly BAUD_DIV+1 cycles with tx_transmit=1, so at least one baud tick sees the request; the FSM SHALL then enter WAIT with tx_transmit=0.
REQ-019 WAIT SHALL last exactly (FRAME_BITS+GUARD_BITS+1)*BAUD_DIV cycles, then the FSM SHALL enter IDLE with busy=0.
REQ-020 IDLE SHALL last at least one cycle; the minimum grant-to-grant spacing SHALL be (FRAME_BITS+GUARD_BITS+2)*BAUD_DIV+2 cycles.
REQ-021 tx_data SHALL change only on a grant edge.
REQ-022 req SHALL be ignored outside IDLE; no request SHALL be queued internally.
REQ-023 A req dropped before being granted SHALL produce no grant and no side effect.
REQ-024 A req still high in the cycle after its gnt SHALL be treated as a new request at the next IDLE.
REQ-025 The phase timer SHALL be one down-counter sized for the largest phase length.
REQ-026 The phase timer SHALL load on every state entry and SHALL NOT wrap.
REQ-027 tx_transmit, tx_data, gnt, busy and last_grant SHALL all be driven directly from registers.

Reset
REQ-028 On reset=0, the block SHALL asynchronously set state=IDLE, gnt=0, tx_transmit=0, tx_data=8'h00, busy=0, last_grant=2'd3 and timer=0.
REQ-029 A reset asserted mid-frame SHALL drop tx_transmit and busy immediately, with no grant issued.
REQ-030 After reset release, the first grant SHALL occur no earlier than the second rising edge.

Verification (BAUD_DIV=4, FRAME_BITS=10, GUARD_BITS=1)
REQ-031 Single request: req=4'b0100 with byte A5 -> gnt=4'b0100 for one cycle; tx_transmit high 5 cycles; tx_data=A5; busy high 53 cycles; last_grant=2.
REQ-032 Contention: req=4'b1111 held (each requester drops its req after its gnt) -> grants in order 0,1,2,3, spaced 54 cycles apart.
REQ-033 Fairness: req0 and req3 both held continuously -> grants alternate 0,3,0,3.
REQ-034 Ignored request: req1 raised and dropped during WAIT -> no gnt1; tx_data unchanged.
REQ-035 Mid-frame reset: reset=0 in cycle 10 of WAIT -> tx_transmit=0, busy=0, state=IDLE; after release with req=4'b1000, the next grant goes to requester 3 (search order starts at 0).
REQ-036 End-to-end: frames from the instantiated transmitter decode as the granted bytes, with no overlapping frames.
